// File: rtl/lpif_tx_arbiter_pkg.sv
// Shared types and helpers for the LPIF transmit arbiter and its output register.
package lpif_tx_arbiter_pkg;

    localparam int DLLP_BYTES    = 6;
    localparam int MAX_BUS_BYTES = 64;

    typedef enum logic [0:0] {
        ARB_IDLE      = 1'b0,
        ARB_TLP_BURST = 1'b1
    } lpif_arb_state_t;

    typedef struct packed {
        logic tlpstart;
        logic tlpend;
        logic dlpstart;
        logic dlpend;
    } lpif_frame_t;

    // Low-byte mask for a beat carrying nbytes; 0 or oversize means a full beat.
    function automatic logic [MAX_BUS_BYTES-1:0] lpif_byte_mask(input logic [7:0] nbytes,
                                                                input int         bus_bytes);
        logic [MAX_BUS_BYTES-1:0] m;
        int                       n;
        n = int'(nbytes);
        if (n == 0 || n > bus_bytes) n = bus_bytes;
        for (int i = 0; i < MAX_BUS_BYTES; i++) m[i] = (i < n);
        return m;
    endfunction

endpackage

// File: rtl/lpif_tx_out_reg.sv
// One-stage LPIF beat holding register: loads when empty or draining, holds under
// back-pressure, and zeroes data bytes outside the byte-valid mask.
module lpif_tx_out_reg
    import lpif_tx_arbiter_pkg::*;
#(
    parameter int BYTES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld,
    input  logic [BYTES*8-1:0] ld_data,
    input  logic [BYTES-1:0]   ld_mask,
    input  lpif_frame_t        ld_frame,
    input  logic               trdy,
    output logic               can_load,
    output logic               irdy,
    output logic [BYTES*8-1:0] data,
    output logic [BYTES-1:0]   valid,
    output lpif_frame_t        frame
);

    logic [BYTES*8-1:0] data_m;

    always_comb begin
        data_m = '0;
        for (int b = 0; b < BYTES; b++) data_m[b*8 +: 8] = ld_data[b*8 +: 8] & {8{ld_mask[b]}};
    end

    assign can_load = !irdy || trdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irdy  <= 1'b0;
            data  <= '0;
            valid <= '0;
            frame <= '0;
        end else if (can_load) begin
            // An empty slot reads back as all-zero so stale framing never lingers.
            irdy  <= ld;
            data  <= ld ? data_m   : '0;
            valid <= ld ? ld_mask  : '0;
            frame <= ld ? ld_frame : '0;
        end
    end

endmodule

// File: rtl/lpif_tx_arbiter.sv
// Packet-boundary arbiter between a DLLP source and a TLP source onto one LPIF
// transmit beat stream; DLLPs win unless they have starved a pending TLP too long.
module lpif_tx_arbiter
    import lpif_tx_arbiter_pkg::*;
#(
    parameter int BUS_BYTES       = 8,
    parameter int MAX_DLLP_STREAK = 4
) (
    input  logic                           lclk,
    input  logic                           reset,
    input  logic                           arb_enable,
    input  logic                           dllp_valid,
    input  logic [47:0]                    dllp_data,
    output logic                           dllp_ready,
    input  logic                           tlp_valid,
    input  logic [BUS_BYTES*8-1:0]         tlp_data,
    input  logic                           tlp_sop,
    input  logic                           tlp_eop,
    input  logic [$clog2(BUS_BYTES):0]     tlp_nbytes,
    output logic                           tlp_ready,
    output logic                           lp_irdy,
    output logic [BUS_BYTES*8-1:0]         lp_data,
    output logic [BUS_BYTES-1:0]           lp_valid,
    output logic                           lp_tlpstart,
    output logic                           lp_tlpend,
    output logic                           lp_dlpstart,
    output logic                           lp_dlpend,
    input  logic                           pl_trdy,
    output logic                           err_sop,
    output logic [15:0]                    dllp_cnt,
    output logic [15:0]                    tlp_cnt
);

    if (BUS_BYTES != 8 && BUS_BYTES != 16 && BUS_BYTES != 32 && BUS_BYTES != 64) begin : g_bad_bus
        $error("lpif_tx_arbiter: BUS_BYTES must be 8, 16, 32 or 64");
    end
    if (MAX_DLLP_STREAK < 1 || MAX_DLLP_STREAK > 15) begin : g_bad_streak
        $error("lpif_tx_arbiter: MAX_DLLP_STREAK must be 1..15");
    end

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DLLP_STREAK);
    localparam logic [BUS_BYTES-1:0] DLLP_MASK =
        BUS_BYTES'({DLLP_BYTES{1'b1}});

    lpif_arb_state_t        state;
    logic [3:0]             streak;
    logic                   can_load;
    logic                   grant_d, grant_t, in_idle, drop, ld;
    logic [BUS_BYTES*8-1:0] ld_data;
    logic [BUS_BYTES-1:0]   ld_mask, tlp_mask;
    lpif_frame_t            ld_frame, lp_frame;

    assign in_idle  = (state == ARB_IDLE);
    assign tlp_mask = BUS_BYTES'(lpif_byte_mask(8'(tlp_nbytes), BUS_BYTES));

    // Readies come only from state, slot availability, enable and the valids.
    always_comb begin
        grant_d    = 1'b0;
        grant_t    = 1'b0;
        dllp_ready = 1'b0;
        tlp_ready  = 1'b0;
        if (!reset) begin
            if (!in_idle) begin
                tlp_ready = can_load;
                grant_t   = can_load && tlp_valid;
            end else if (can_load && arb_enable) begin
                if (dllp_valid && (!tlp_valid || streak < STREAK_MAX)) begin
                    dllp_ready = 1'b1;
                    grant_d    = 1'b1;
                end else if (tlp_valid) begin
                    tlp_ready = 1'b1;
                    grant_t   = 1'b1;
                end
            end
        end
    end

    // A headless TLP beat offered between packets is swallowed, not forwarded.
    assign drop = grant_t && in_idle && !tlp_sop;
    assign ld   = grant_d || (grant_t && !drop);

    always_comb begin
        ld_frame          = '0;
        ld_frame.dlpstart = grant_d;
        ld_frame.dlpend   = grant_d;
        ld_frame.tlpstart = grant_t && in_idle && tlp_sop;
        ld_frame.tlpend   = grant_t && tlp_eop;
        ld_data           = grant_d ? {{(BUS_BYTES-DLLP_BYTES)*8{1'b0}}, dllp_data} : tlp_data;
        ld_mask           = grant_d ? DLLP_MASK : tlp_mask;
    end

    always_ff @(posedge lclk or posedge reset) begin
        if (reset) begin
            state   <= ARB_IDLE;
            streak  <= '0;
            err_sop <= 1'b0;
        end else begin
            err_sop <= drop;
            if (grant_d)                 streak <= tlp_valid ? streak + 4'd1 : 4'd0;
            else if (grant_t && in_idle) streak <= '0;
            if (grant_t) begin
                if (in_idle && tlp_sop && !tlp_eop) state <= ARB_TLP_BURST;
                else if (!in_idle && tlp_eop)       state <= ARB_IDLE;
            end
        end
    end

    always_ff @(posedge lclk or posedge reset) begin
        if (reset) begin
            dllp_cnt <= '0;
            tlp_cnt  <= '0;
        end else if (lp_irdy && pl_trdy) begin
            if (lp_dlpend) dllp_cnt <= dllp_cnt + 16'd1;
            if (lp_tlpend) tlp_cnt  <= tlp_cnt + 16'd1;
        end
    end

    lpif_tx_out_reg #(.BYTES(BUS_BYTES)) u_out_reg (
        .clk      (lclk),
        .rst      (reset),
        .ld       (ld),
        .ld_data  (ld_data),
        .ld_mask  (ld_mask),
        .ld_frame (ld_frame),
        .trdy     (pl_trdy),
        .can_load (can_load),
        .irdy     (lp_irdy),
        .data     (lp_data),
        .valid    (lp_valid),
        .frame    (lp_frame)
    );

    assign lp_tlpstart = lp_frame.tlpstart;
    assign lp_tlpend   = lp_frame.tlpend;
    assign lp_dlpstart = lp_frame.dlpstart;
    assign lp_dlpend   = lp_frame.dlpend;

endmodule
